// File: rtl/nibble_sort_seq_pkg.sv
// Shared constants for the sequential 4-element sorter: element count,
// step count and the compare-exchange schedule of the 4-input network.
package sort_pkg;

  localparam int N_ELEM  = 4;
  localparam int N_STEPS = 5;

  // Entry s is the (a,b) pair for step s: (0,2) (1,3) (0,1) (2,3) (1,2).
  localparam logic [N_STEPS-1:0][1:0] STEP_A = {2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic [N_STEPS-1:0][1:0] STEP_B = {2'd2, 2'd3, 2'd1, 2'd3, 2'd2};

  typedef enum logic [1:0] {IDLE, SORT, DONE} sort_state_t;

endpackage

// File: rtl/nibble_sort_seq_if.sv
// Producer/consumer bundle of the sorter: start + packed operands in,
// busy/done status and the packed sorted result out.
interface nibble_sort_seq_if #(parameter int W = 4);
  import sort_pkg::*;

  logic                  start;
  logic [N_ELEM*W-1:0]   i;
  logic                  busy;
  logic                  done;
  logic [N_ELEM*W-1:0]   o;

  modport master (output start, i, input  busy, done, o);
  modport slave  (input  start, i, output busy, done, o);

endinterface

// File: rtl/nibble_sort_seq_comparator.sv
// Unsigned compare-exchange cell: routes the lesser operand to lo_o and the
// greater to hi_o.
module comparator #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o
);

  logic swap;

  assign swap = a_i > b_i;
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/nibble_sort_seq.sv
// Area-lean 4-element sorter: one comparator is time-shared across the five
// compare-exchange steps of the 4-input sorting network.
module nibble_sort_seq
  import sort_pkg::*;
#(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  nibble_sort_seq_if.slave  bus
);

  sort_state_t                 state_q;
  logic [2:0]                  step_q;
  logic [N_ELEM-1:0][W-1:0]    r_q, r_d;
  logic [N_ELEM*W-1:0]         o_q;
  logic                        busy_q, done_q;

  logic [1:0]                  a_idx, b_idx;
  logic [W-1:0]                lo, hi;

  assign a_idx = STEP_A[step_q];
  assign b_idx = STEP_B[step_q];

  comparator #(.W(W)) u_cmp (
    .a_i  (r_q[a_idx]),
    .b_i  (r_q[b_idx]),
    .lo_o (lo),
    .hi_o (hi)
  );

  always_comb begin
    r_d        = r_q;
    r_d[a_idx] = lo;
    r_d[b_idx] = hi;
  end

  // Result register is loaded from r_d so the last swap lands in o directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      r_q     <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            r_q     <= bus.i;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SORT;
          end
        end
        SORT: begin
          r_q    <= r_d;
          step_q <= step_q + 3'd1;
          if (step_q == 3'(N_STEPS - 1)) begin
            o_q     <= r_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          step_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.o    = o_q;

endmodule

// File: tb/tb_nibble_sort_seq.sv
// Randomized self-checking bench for nibble_sort_seq against a transaction
// level reference (plain array sort + cycle count since acceptance).
module tb_nibble_sort_seq;

  localparam int W = 4;

  logic clk, rst;
  int   checks = 0;
  int   failures = 0;

  nibble_sort_seq_if #(.W(W)) bus ();

  nibble_sort_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sortw(input logic [15:0] v);
    int e [4];
    int t;
    logic [15:0] r;
    for (int k = 0; k < 4; k++) e[k] = int'(v[k*4 +: 4]);
    for (int p = 1; p < 4; p++)
      for (int q = p; q > 0 && e[q-1] > e[q]; q--) begin
        t = e[q]; e[q] = e[q-1]; e[q-1] = t;
      end
    r = '0;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(e[k]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: cnt = cycles since acceptance (0 when idle); result appears at 6.
  int          m_cnt = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_o = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_o   = '0;
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        m_cnt  = 1;
        m_pend = sortw(bus.i);
      end
    end else if (m_cnt == 6) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 6) m_o = m_pend;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {15'd0, bus.busy}, {15'd0, m_cnt != 0});
    chk("cyc_done", {15'd0, bus.done}, {15'd0, m_cnt == 6});
    chk("cyc_o",    bus.o, m_o);
  end

  // Accepts v on the next edge, toggles start/i randomly mid-sort, then checks
  // latency, busy duration and the result.
  task automatic do_sort(input logic [15:0] v, input logic [15:0] exp, input string nm);
    int n, bc;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.i = v;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.i = 16'($urandom);
    n = 0; bc = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy === 1'b1) bc++;
      bus.start = 1'($urandom_range(0, 1));
      bus.i     = 16'($urandom);
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 16'(n), 16'd5);
    chk({nm, "_busy_cycles"}, 16'(bc), 16'd6);
    chk({nm, "_o"}, bus.o, exp);
  endtask

  initial begin
    int n;
    logic [15:0] v;
    rst = 1'b1; bus.start = 1'b0; bus.i = '0;

    // model pinning
    chk("model_1234", sortw(16'h1234), 16'h4321);
    chk("model_A5F0", sortw(16'hA5F0), 16'hFA50);
    chk("model_0F0F", sortw(16'h0F0F), 16'hFF00);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", bus.o, 16'h0000);
    chk("rst_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);

    do_sort(16'h1234, 16'h4321, "s1234");
    do_sort(16'hA5F0, 16'hFA50, "sA5F0");
    do_sort(16'h7777, 16'h7777, "s7777");
    do_sort(16'h4321, 16'h4321, "s4321");

    // start held high: back-to-back sorts every 7 cycles
    @(posedge clk); #1;
    bus.start = 1'b1; bus.i = 16'h1234;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("held1_o", bus.o, 16'h4321);
    bus.i = 16'h0F0F;
    n = 0;
    @(posedge clk); #1; n++;
    while (bus.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("held_period", 16'(n), 16'd7);
    chk("held2_o", bus.o, 16'hFF00);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);

    // reset while step 2 is pending
    @(posedge clk); #1;
    bus.start = 1'b1; bus.i = 16'hA5F0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_o", bus.o, 16'h0000);
    chk("midrst_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n++;
    end
    chk("midrst_no_done", 16'(n), 16'd0);
    do_sort(16'h1234, 16'h4321, "post_rst");

    for (int k = 0; k < 1000; k++) begin
      v = 16'($urandom);
      do_sort(v, sortw(v), "rand");
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
